// File: rtl/puf_ctrl_pkg.sv
// Shared definitions for the PUF evaluation controller.
//   state_t  : controller FSM states
//   TUNE_W   : width of the PUF tune_level bus
//   TUNE_MAX : highest tune level the PUF decoder accepts
//   clog2()  : counter width helper, never returns less than 1
package puf_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FIRE,
        SAMPLE,
        DONE
    } state_t;

    localparam int TUNE_W   = 5;
    localparam int TUNE_MAX = 16;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >>> 1;
        end
        return (result < 1) ? 1 : result;
    endfunction

endpackage

// File: rtl/puf_resp_sync.sv
// Two-flop synchronizer for a bus of independent asynchronous bits.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset, both stages clear to 0
//   d     : asynchronous input bits
//   q     : synchronized output bits (2 cycles latency)
module puf_resp_sync #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/puf_eval_ctrl.sv
// Sequencer in front of the PUF core. Accepts a challenge pair plus tune
// level, fires the PUF REPS times (SETTLE cycles of puf_start high, then one
// sample cycle low), majority-votes every response bit and returns the
// voted 2N-bit response over a valid/ready handshake.
//   clk, rst_n                       : clock, asynchronous active-low reset
//   req_valid/req_ready              : request handshake
//   req_c1, req_c2, req_tune         : request payload
//   puf_challenge1/2, puf_tune_level : latched PUF configuration
//   puf_start                        : PUF evaluation strobe
//   puf_response                     : raw PUF outputs, asynchronous to clk
//   rsp_valid/rsp_ready, rsp_data    : voted response handshake
//   busy                             : controller not in IDLE
// Optional macro PUF_UNSTABLE_MASK_EN adds rsp_unstable: bit i set when that
// response bit was not unanimous across the REPS evaluations.
module puf_eval_ctrl
    import puf_ctrl_pkg::*;
#(
    parameter int N        = 4,
    parameter int SETTLE   = 8,
    parameter int REPS     = 5,
    parameter int TUNE_MAX = puf_ctrl_pkg::TUNE_MAX
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [N-1:0]      req_c1,
    input  logic [N-1:0]      req_c2,
    input  logic [TUNE_W-1:0] req_tune,
    output logic [N-1:0]      puf_challenge1,
    output logic [N-1:0]      puf_challenge2,
    output logic [TUNE_W-1:0] puf_tune_level,
    output logic              puf_start,
    input  logic [2*N-1:0]    puf_response,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [2*N-1:0]    rsp_data,
    output logic              busy
`ifdef PUF_UNSTABLE_MASK_EN
    ,
    output logic [2*N-1:0]    rsp_unstable
`endif
);

    localparam int CW = clog2(REPS + 1);
    localparam int SW = clog2(SETTLE);

    localparam logic [SW-1:0]     SETTLE_LAST = SW'(SETTLE - 1);
    localparam logic [CW-1:0]     REPS_LAST   = CW'(REPS - 1);
    localparam logic [CW-1:0]     REPS_ALL    = CW'(REPS);
    localparam logic [CW-1:0]     HALF        = CW'(REPS / 2);
    localparam logic [TUNE_W-1:0] TUNE_CAP    = TUNE_W'(TUNE_MAX);

    if ((REPS % 2) == 0 || REPS < 1) begin : g_bad_reps
        $error("puf_eval_ctrl: REPS must be odd and >= 1");
    end
    if (SETTLE < 3) begin : g_bad_settle
        $error("puf_eval_ctrl: SETTLE must be >= 3");
    end

    state_t          state;
    state_t          state_nxt;
    logic            accept;
    logic            last_rep;
    logic [SW-1:0]   settle_cnt;
    logic [CW-1:0]   rep_cnt;
    logic [CW-1:0]   ones     [2*N];
    logic [CW-1:0]   ones_nxt [2*N];
    logic [2*N-1:0]  resp_sync;
    logic [2*N-1:0]  vote;
`ifdef PUF_UNSTABLE_MASK_EN
    logic [2*N-1:0]  unstable;
`endif

    puf_resp_sync #(
        .W(2 * N)
    ) u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (puf_response),
        .q    (resp_sync)
    );

    // Status outputs decode straight from state so an asynchronous reset
    // drops puf_start without waiting for a clock edge.
    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign puf_start = (state == FIRE);
    assign rsp_valid = (state == DONE);
    assign last_rep  = (rep_cnt == REPS_LAST);

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    accept    = 1'b1;
                    state_nxt = FIRE;
                end
            end
            FIRE: begin
                if (settle_cnt == SETTLE_LAST) begin
                    state_nxt = SAMPLE;
                end
            end
            SAMPLE: begin
                state_nxt = last_rep ? DONE : FIRE;
            end
            DONE: begin
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Vote on the counts including the sample taken this cycle, so rsp_data
    // is registered on the same edge that enters DONE.
    always_comb begin
        vote = '0;
`ifdef PUF_UNSTABLE_MASK_EN
        unstable = '0;
`endif
        for (int unsigned i = 0; i < 2 * N; i++) begin
            ones_nxt[i] = ones[i] + CW'(resp_sync[i]);
            vote[i]     = (ones_nxt[i] > HALF);
`ifdef PUF_UNSTABLE_MASK_EN
            unstable[i] = (ones_nxt[i] != '0) && (ones_nxt[i] != REPS_ALL);
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            settle_cnt     <= '0;
            rep_cnt        <= '0;
            puf_challenge1 <= '0;
            puf_challenge2 <= '0;
            puf_tune_level <= '0;
            rsp_data       <= '0;
`ifdef PUF_UNSTABLE_MASK_EN
            rsp_unstable   <= '0;
`endif
            for (int unsigned i = 0; i < 2 * N; i++) begin
                ones[i] <= '0;
            end
        end else begin
            state <= state_nxt;
            if (accept) begin
                puf_challenge1 <= req_c1;
                puf_challenge2 <= req_c2;
                puf_tune_level <= (req_tune > TUNE_CAP) ? TUNE_CAP : req_tune;
                settle_cnt     <= '0;
                rep_cnt        <= '0;
                for (int unsigned i = 0; i < 2 * N; i++) begin
                    ones[i] <= '0;
                end
            end
            if (state == FIRE) begin
                settle_cnt <= (settle_cnt == SETTLE_LAST) ? '0 : settle_cnt + 1'b1;
            end
            if (state == SAMPLE) begin
                rep_cnt <= rep_cnt + 1'b1;
                for (int unsigned i = 0; i < 2 * N; i++) begin
                    ones[i] <= ones_nxt[i];
                end
                if (last_rep) begin
                    rsp_data     <= vote;
`ifdef PUF_UNSTABLE_MASK_EN
                    rsp_unstable <= unstable;
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_puf_eval_ctrl.sv
// Self-checking bench for puf_eval_ctrl (default parameters N=4, SETTLE=8,
// REPS=5). A behavioural PUF drives puf_response on every puf_start rise;
// expected votes are pushed to a queue per request and popped at rsp_valid.
module tb_puf_eval_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid;
    logic       req_ready;
    logic [3:0] req_c1;
    logic [3:0] req_c2;
    logic [4:0] req_tune;
    logic [3:0] puf_challenge1;
    logic [3:0] puf_challenge2;
    logic [4:0] puf_tune_level;
    logic       puf_start;
    logic [7:0] puf_response = 8'h00;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;
    logic       busy;
`ifdef PUF_UNSTABLE_MASK_EN
    logic [7:0] rsp_unstable;
    logic [7:0] q_unst[$];
`endif

    int checks   = 0;
    int failures = 0;

    logic [7:0] q_data[$];

    // Behavioural PUF state
    int         eval_idx    = 0;
    logic [7:0] model_base  = 8'h00;
    logic [7:0] model_flip  = 8'h00;
    logic [4:0] model_evals = 5'b00000;

    always #5 clk = ~clk;

    puf_eval_ctrl #(
        .N       (4),
        .SETTLE  (8),
        .REPS    (5),
        .TUNE_MAX(16)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_c1        (req_c1),
        .req_c2        (req_c2),
        .req_tune      (req_tune),
        .puf_challenge1(puf_challenge1),
        .puf_challenge2(puf_challenge2),
        .puf_tune_level(puf_tune_level),
        .puf_start     (puf_start),
        .puf_response  (puf_response),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_data      (rsp_data),
        .busy          (busy)
`ifdef PUF_UNSTABLE_MASK_EN
        ,
        .rsp_unstable  (rsp_unstable)
`endif
    );

    always @(posedge puf_start) begin
        if (eval_idx < 5 && model_evals[eval_idx]) begin
            puf_response = model_base ^ model_flip;
        end else begin
            puf_response = model_base;
        end
        eval_idx = eval_idx + 1;
    end

    // Expected vote (or non-unanimous mask) over the 5 modelled evaluations.
    function automatic logic [7:0] vote_of(input logic [7:0] base, input logic [7:0] flip,
                                           input logic [4:0] evals, input bit want_unstable);
        logic [7:0] res;
        logic [7:0] v;
        int cnt;
        res = 8'h00;
        for (int b = 0; b < 8; b++) begin
            cnt = 0;
            for (int e = 0; e < 5; e++) begin
                v = evals[e] ? (base ^ flip) : base;
                cnt += v[b] ? 1 : 0;
            end
            res[b] = want_unstable ? (cnt != 0 && cnt != 5) : (cnt >= 3);
        end
        return res;
    endfunction

    // Drives one request; returns 1 time unit after the accepting edge.
    task automatic send_req(input logic [3:0] c1, input logic [3:0] c2, input logic [4:0] tune);
        int guard;
        @(negedge clk);
        guard = 0;
        while (!req_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (req_ready !== 1'b1) begin
            failures++;
            $display("FAIL send_req_ready: req_ready=%b required 1", req_ready);
        end
        eval_idx  = 0;
        req_c1    = c1;
        req_c2    = c2;
        req_tune  = tune;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        q_data.push_back(vote_of(model_base, model_flip, model_evals, 1'b0));
`ifdef PUF_UNSTABLE_MASK_EN
        q_unst.push_back(vote_of(model_base, model_flip, model_evals, 1'b1));
`endif
    endtask

    // Called 1 unit after an accepting edge: checks start pattern and latency.
    task automatic run_latency(input string name);
        int bad_start;
        int first_valid;
        logic exp_start;
        bad_start   = 0;
        first_valid = -1;
        for (int k = 0; k <= 45; k++) begin
            exp_start = (k < 45) && ((k % 9) != 8);
            if (puf_start !== exp_start) bad_start++;
            if (rsp_valid === 1'b1 && first_valid < 0) first_valid = k;
            if (k < 45) begin
                @(posedge clk);
                #1;
            end
        end
        checks++;
        if (bad_start != 0) begin
            failures++;
            $display("FAIL %s_start_pattern: %0d wrong cycles required 0", name, bad_start);
        end
        checks++;
        if (first_valid != 45) begin
            failures++;
            $display("FAIL %s_latency: rsp_valid first at edge %0d required 45", name, first_valid);
        end
    endtask

    // Waits (bounded) for rsp_valid, compares against the scoreboard, handshakes.
    task automatic wait_rsp(input string name);
        int guard;
        logic [7:0] exp;
        guard = 0;
        while (rsp_valid !== 1'b1 && guard < 200) begin
            @(posedge clk);
            #1;
            guard++;
        end
        checks++;
        if (rsp_valid !== 1'b1) begin
            failures++;
            $display("FAIL %s_rsp_valid: rsp_valid=%b required 1 (timeout)", name, rsp_valid);
        end
        exp = (q_data.size() > 0) ? q_data.pop_front() : 8'hxx;
        checks++;
        if (rsp_data !== exp) begin
            failures++;
            $display("FAIL %s_rsp_data: got %h required %h", name, rsp_data, exp);
        end
`ifdef PUF_UNSTABLE_MASK_EN
        exp = (q_unst.size() > 0) ? q_unst.pop_front() : 8'hxx;
        checks++;
        if (rsp_unstable !== exp) begin
            failures++;
            $display("FAIL %s_rsp_unstable: got %h required %h", name, rsp_unstable, exp);
        end
`endif
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s_handshake_idle: rsp_valid=%b req_ready=%b required 0/1",
                     name, rsp_valid, req_ready);
        end
    endtask

    task automatic check_reset_values(input string name);
        checks++;
        if ({req_ready, rsp_valid, busy, puf_start} !== 4'b1000 ||
            rsp_data !== 8'h00 || puf_challenge1 !== 4'h0 ||
            puf_challenge2 !== 4'h0 || puf_tune_level !== 5'd0) begin
            failures++;
            $display("FAIL %s: rdy/vld/busy/start=%b%b%b%b data=%h c1=%h c2=%h tune=%0d required 1000 00 0 0 0",
                     name, req_ready, rsp_valid, busy, puf_start, rsp_data,
                     puf_challenge1, puf_challenge2, puf_tune_level);
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        req_c1    = 4'h0;
        req_c2    = 4'h0;
        req_tune  = 5'd0;
        #1;
        check_reset_values("reset_asserted");
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_reset_values("reset_released");
    endtask

    task automatic test_basic();
        model_base  = 8'h0F;
        model_flip  = 8'h00;
        model_evals = 5'b00000;
        send_req(4'h3, 4'h5, 5'd7);
        checks++;
        if (puf_challenge1 !== 4'h3 || puf_challenge2 !== 4'h5 || puf_tune_level !== 5'd7) begin
            failures++;
            $display("FAIL basic_latch: c1=%h c2=%h tune=%0d required 3 5 7",
                     puf_challenge1, puf_challenge2, puf_tune_level);
        end
        run_latency("basic");
        wait_rsp("basic");
        checks++;
        if (puf_challenge1 !== 4'h3 || puf_tune_level !== 5'd7) begin
            failures++;
            $display("FAIL basic_hold_after_done: c1=%h tune=%0d required 3 7",
                     puf_challenge1, puf_tune_level);
        end
    endtask

    task automatic test_tune_clamp();
        logic [4:0] tunes [5] = '{5'd15, 5'd16, 5'd17, 5'd25, 5'd31};
        logic [4:0] exps  [5] = '{5'd15, 5'd16, 5'd16, 5'd16, 5'd16};
        model_base = 8'h3C;
        for (int i = 0; i < 5; i++) begin
            send_req(4'h1, 4'h2, tunes[i]);
            checks++;
            if (puf_tune_level !== exps[i]) begin
                failures++;
                $display("FAIL tune_clamp_%0d: puf_tune_level=%0d required %0d",
                         tunes[i], puf_tune_level, exps[i]);
            end
            wait_rsp("tune_clamp");
        end
    endtask

    task automatic test_vote();
        model_base  = 8'h00;
        model_flip  = 8'h01;
        model_evals = 5'b01010;   // bit 0 set in 2 of 5 evaluations
        send_req(4'h6, 4'h9, 5'd3);
        wait_rsp("vote_2of5");
        model_evals = 5'b10101;   // bit 0 set in 3 of 5 evaluations
        send_req(4'h6, 4'h9, 5'd3);
        wait_rsp("vote_3of5");
        model_base  = 8'hA0;
        model_flip  = 8'hFF;
        model_evals = 5'b11000;   // every bit disagrees in 2 of 5
        send_req(4'hC, 4'h2, 5'd9);
        wait_rsp("vote_mixed");
        model_flip  = 8'h00;
        model_evals = 5'b00000;
    endtask

    task automatic test_backpressure();
        int guard;
        logic [7:0] exp;
        model_base = 8'h5A;
        send_req(4'hE, 4'h7, 5'd4);
        guard = 0;
        while (rsp_valid !== 1'b1 && guard < 200) begin
            @(posedge clk);
            #1;
            guard++;
        end
        exp = (q_data.size() > 0) ? q_data[0] : 8'hxx;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            req_valid = $urandom_range(0, 1);
            req_c1    = 4'($urandom_range(0, 15));
            @(posedge clk);
            #1;
            checks++;
            if (rsp_valid !== 1'b1 || rsp_data !== exp || req_ready !== 1'b0 ||
                puf_start !== 1'b0 || puf_challenge1 !== 4'hE) begin
                failures++;
                $display("FAIL backpressure_hold_%0d: vld=%b data=%h rdy=%b start=%b c1=%h required 1 %h 0 0 e",
                         c, rsp_valid, rsp_data, req_ready, puf_start, puf_challenge1, exp);
            end
        end
        @(negedge clk) req_valid = 1'b0;
        #4;
        wait_rsp("backpressure");
    endtask

    task automatic test_async_reset();
        model_base = 8'h0F;
        send_req(4'hB, 4'hD, 5'd20);
        repeat (21) @(posedge clk);   // edge 21 after acceptance: third FIRE
        #2;
        checks++;
        if (puf_start !== 1'b1) begin
            failures++;
            $display("FAIL async_pre_fire: puf_start=%b required 1", puf_start);
        end
        rst_n = 1'b0;
        #1;
        check_reset_values("async_reset_values");
        void'(q_data.pop_back());
`ifdef PUF_UNSTABLE_MASK_EN
        void'(q_unst.pop_back());
`endif
        @(negedge clk) rst_n = 1'b1;
        model_base = 8'hC3;
        send_req(4'h3, 4'h5, 5'd7);
        run_latency("after_reset");
        wait_rsp("after_reset");
    endtask

    task automatic test_back_to_back();
        int guard;
        int early_ready;
        int overlap;
        model_base = 8'h96;
        @(negedge clk);
        eval_idx  = 0;
        req_c1    = 4'h1;
        req_c2    = 4'h2;
        req_tune  = 5'd3;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        q_data.push_back(vote_of(model_base, model_flip, model_evals, 1'b0));
`ifdef PUF_UNSTABLE_MASK_EN
        q_unst.push_back(vote_of(model_base, model_flip, model_evals, 1'b1));
`endif
        req_c1   = 4'h8;
        req_c2   = 4'h4;
        req_tune = 5'd11;
        early_ready = 0;
        overlap     = 0;
        guard       = 0;
        while (rsp_valid !== 1'b1 && guard < 200) begin
            if (req_ready !== 1'b0 || puf_challenge1 !== 4'h1) early_ready++;
            @(posedge clk);
            #1;
            guard++;
        end
        checks++;
        if (early_ready != 0) begin
            failures++;
            $display("FAIL b2b_no_early_accept: %0d bad cycles required 0", early_ready);
        end
        model_base = 8'h69;
        eval_idx   = 0;
        q_data.push_back(vote_of(model_base, model_flip, model_evals, 1'b0));
`ifdef PUF_UNSTABLE_MASK_EN
        q_unst.push_back(vote_of(model_base, model_flip, model_evals, 1'b1));
`endif
        wait_rsp("b2b_first");
        // Now IDLE with req_valid still high: the next edge accepts request 2.
        checks++;
        if (puf_start !== 1'b0 || puf_challenge1 !== 4'h1) begin
            failures++;
            $display("FAIL b2b_idle_gap: start=%b c1=%h required 0 1", puf_start, puf_challenge1);
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        checks++;
        if (puf_start !== 1'b1 || puf_challenge1 !== 4'h8 || puf_tune_level !== 5'd11) begin
            failures++;
            $display("FAIL b2b_second_accept: start=%b c1=%h tune=%0d required 1 8 11",
                     puf_start, puf_challenge1, puf_tune_level);
        end
        guard = 0;
        while (rsp_valid !== 1'b1 && guard < 200) begin
            if (puf_start === 1'b1 && rsp_valid === 1'b1) overlap++;
            @(posedge clk);
            #1;
            guard++;
        end
        checks++;
        if (overlap != 0) begin
            failures++;
            $display("FAIL b2b_overlap: %0d cycles required 0", overlap);
        end
        wait_rsp("b2b_second");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_tune_clamp();
        test_vote();
        test_backpressure();
        test_async_reset();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
